// File: rtl/mem_arbiter_if.sv
// Bus between the fetch/data requesters, the arbiter and the single-port memory.
// The slave modport is the arbiter's view; master is the requester/memory side.
interface mem_arbiter_if #(
  parameter int AW = 5,
  parameter int DW = 16
);
  logic          f_req;
  logic          f_we;
  logic [AW-1:0] f_addr;
  logic [DW-1:0] f_wdata;
  logic          d_req;
  logic          d_we;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          f_ack;
  logic          d_ack;
  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_write_n;
  logic          mem_read_n;
  logic [DW-1:0] mem_dout;
  logic          busy;

  modport slave (
    input  f_req, f_we, f_addr, f_wdata,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_dout,
    output f_ack, d_ack, rdata, mem_addr, mem_din, mem_write_n, mem_read_n, busy
  );

  modport master (
    output f_req, f_we, f_addr, f_wdata,
    output d_req, d_we, d_addr, d_wdata,
    output mem_dout,
    input  f_ack, d_ack, rdata, mem_addr, mem_din, mem_write_n, mem_read_n, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for a single-port memory sampled on the falling clock edge.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on ties; otherwise the data port has fixed priority.
module mem_arbiter #(
  parameter int AW = 5,
  parameter int DW = 16
) (
  input  logic         clk,
  input  logic         proc_rst,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_we;
  logic          r_id;
  logic          r_read_n, r_write_n, r_f_ack, r_d_ack;
  logic          w_read_n_nxt, w_write_n_nxt, w_f_ack_nxt, w_d_ack_nxt;
  logic          w_accept, w_grant_d, w_we_sel;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  // r_last_d starts at 1 so the first tie after reset goes to fetch.
  logic r_last_d;
  always_comb w_grant_d = bus.d_req & (~bus.f_req | ~r_last_d);

  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst)     r_last_d <= 1'b1;
    else if (w_accept) r_last_d <= w_grant_d;
  end
`else
  always_comb w_grant_d = bus.d_req;
`endif

  assign w_accept = (r_state == S_IDLE) && (bus.f_req || bus.d_req);
  assign w_we_sel = w_grant_d ? bus.d_we : bus.f_we;

  always_comb begin
    w_state_nxt   = r_state;
    w_read_n_nxt  = 1'b1;
    w_write_n_nxt = 1'b1;
    w_f_ack_nxt   = 1'b0;
    w_d_ack_nxt   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = S_ISSUE;
          w_read_n_nxt  = w_we_sel;
          w_write_n_nxt = ~w_we_sel;
        end
      end
      S_ISSUE: begin
        w_state_nxt = S_DONE;
        w_f_ack_nxt = ~r_id;
        w_d_ack_nxt = r_id;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Strobes and acks are flops so the memory sees clean levels at its falling-edge sample.
  always_ff @(posedge clk or negedge proc_rst) begin
    if (!proc_rst) begin
      r_state   <= S_IDLE;
      r_read_n  <= 1'b1;
      r_write_n <= 1'b1;
      r_f_ack   <= 1'b0;
      r_d_ack   <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_rdata   <= '0;
      r_we      <= 1'b0;
      r_id      <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_read_n  <= w_read_n_nxt;
      r_write_n <= w_write_n_nxt;
      r_f_ack   <= w_f_ack_nxt;
      r_d_ack   <= w_d_ack_nxt;
      if (w_accept) begin
        r_addr  <= w_grant_d ? bus.d_addr  : bus.f_addr;
        r_wdata <= w_grant_d ? bus.d_wdata : bus.f_wdata;
        r_we    <= w_we_sel;
        r_id    <= w_grant_d;
      end
      if (r_state == S_ISSUE && !r_we) r_rdata <= bus.mem_dout;
    end
  end

  assign bus.f_ack       = r_f_ack;
  assign bus.d_ack       = r_d_ack;
  assign bus.rdata       = r_rdata;
  assign bus.mem_addr    = r_addr;
  assign bus.mem_din     = r_wdata;
  assign bus.mem_write_n = r_write_n;
  assign bus.mem_read_n  = r_read_n;
  assign bus.busy        = (r_state != S_IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed accesses push expectations, a monitor checks each ack.
module tb_mem_arbiter;
  localparam int AW = 5;
  localparam int DW = 16;

  typedef struct packed {
    logic          port;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic proc_rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();
  mem_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .proc_rst(proc_rst), .bus(bus));

  logic [DW-1:0] mem [32];
  exp_t          sbq [$];
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;
  int            last_issue = -100;
  logic [DW-1:0] hold_rdata = '0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory: preloaded while in reset, accessed on the falling edge.
  always @(negedge clk) begin
    if (!proc_rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 16'h1000 + 16'(i);
      mem[2] <= 16'h02E2;
      mem[3] <= 16'h3333;
      mem[4] <= 16'h4444;
    end else begin
      if (!bus.mem_write_n) mem[bus.mem_addr] <= bus.mem_din;
      if (!bus.mem_read_n)  bus.mem_dout <= mem[bus.mem_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic port, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] data);
    exp_t e;
    e.port = port; e.we = we; e.addr = addr; e.data = data;
    return e;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk); #1;
      if (!proc_rst) begin
        chk("rst_strobes", {bus.mem_write_n, bus.mem_read_n}, 2'b11);
        last_issue = -100;
        hold_rdata = '0;
      end else begin
        if (!bus.mem_read_n || !bus.mem_write_n) begin
          chk("strobe_excl", bus.mem_write_n | bus.mem_read_n, 1);
          chk("issue_spacing", (cyc - last_issue) >= 3, 1);
          last_issue = cyc;
          if (sbq.size() > 0) begin
            chk("issue_addr", bus.mem_addr, sbq[0].addr);
            chk("issue_kind", {bus.mem_write_n, bus.mem_read_n}, sbq[0].we ? 2'b01 : 2'b10);
            if (sbq[0].we) chk("issue_din", bus.mem_din, sbq[0].data);
          end
        end
        if (bus.f_ack || bus.d_ack) begin
          chk("ack_onehot", bus.f_ack & bus.d_ack, 0);
          chk("done_strobes", {bus.mem_write_n, bus.mem_read_n}, 2'b11);
          if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ack actual f=%0b d=%0b required none", bus.f_ack, bus.d_ack);
          end else begin
            e = sbq.pop_front();
            chk("ack_port", bus.d_ack, e.port);
            if (e.we) chk("rdata_hold", bus.rdata, hold_rdata);
            else begin
              chk("rdata", bus.rdata, e.data);
              hold_rdata = e.data;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic drive(input bit port, input bit req, input bit we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wd);
    if (port) begin
      bus.d_req = req; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wd;
    end else begin
      bus.f_req = req; bus.f_we = we; bus.f_addr = addr; bus.f_wdata = wd;
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("idle_timeout", bus.busy, 0);
  endtask

  task automatic access(input bit port, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd, input bit scramble);
    int n;
    wait_idle();
    drive(port, 1'b1, we, addr, wd);
    sbq.push_back(mk(port, we, addr, we ? wd : exp_rd));
    @(posedge clk); #1;
    chk("accept_busy", bus.busy, 1);
    if (scramble) drive(port, 1'b1, we, addr ^ 5'h1F, ~wd);
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!(port ? bus.d_ack : bus.f_ack) && n < 8);
    chk("ack_latency", n, 1);
    chk("done_addr", bus.mem_addr, addr);
    drive(port, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    chk("ack_pulse", {bus.f_ack, bus.d_ack}, 2'b00);
    chk("idle_busy", bus.busy, 0);
    chk("idle_addr_hold", bus.mem_addr, addr);
  endtask

  initial begin : stim
    int n;
    int acks;
    drive(1'b0, 1'b0, 1'b0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    proc_rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_n", bus.mem_write_n, 1);
    chk("rst_rd_n", bus.mem_read_n, 1);
    chk("rst_acks", {bus.f_ack, bus.d_ack}, 2'b00);
    chk("rst_busy", bus.busy, 0);
    chk("rst_rdata", bus.rdata, 0);
    chk("rst_addr", bus.mem_addr, 0);
    chk("rst_din", bus.mem_din, 0);
    proc_rst = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle", bus.busy, 0);

    access(1'b1, 1'b0, 5'd2, '0, 16'h02E2, 1'b0);
    access(1'b0, 1'b1, 5'd5, 16'hA5A5, '0, 1'b0);
    chk("mem5_written", mem[5], 16'hA5A5);
    access(1'b0, 1'b0, 5'd5, '0, 16'hA5A5, 1'b0);
    access(1'b1, 1'b1, 5'd7, 16'h1234, '0, 1'b0);
    access(1'b1, 1'b0, 5'd7, '0, 16'h1234, 1'b0);
    access(1'b0, 1'b0, 5'd9, '0, 16'h1009, 1'b1);

    // Reset in the middle of ISSUE: access aborted, request stays up and is served after release.
    wait_idle();
    drive(1'b1, 1'b1, 1'b0, 5'd2, '0);
    @(posedge clk); #1;
    chk("abort_issue", bus.mem_read_n, 0);
    #2 proc_rst = 1'b0;
    #1;
    chk("abort_strobes", {bus.mem_write_n, bus.mem_read_n}, 2'b11);
    chk("abort_busy", bus.busy, 0);
    chk("abort_acks", {bus.f_ack, bus.d_ack}, 2'b00);
    chk("abort_rdata", bus.rdata, 0);
    @(posedge clk); #1;
    chk("abort_no_ack", {bus.f_ack, bus.d_ack}, 2'b00);
    @(posedge clk); #1;
    sbq.push_back(mk(1'b1, 1'b0, 5'd2, 16'h02E2));
    proc_rst = 1'b1;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (!bus.d_ack && n < 8);
    chk("rerequest_latency", n, 2);
    drive(1'b1, 1'b0, 1'b0, '0, '0);
    repeat (4) @(posedge clk);
    #1;
    chk("served_once", sbq.size(), 0);

    // Both ports request continuously from a fresh reset.
    proc_rst = 1'b0;
    @(posedge clk); #1;
    proc_rst = 1'b1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    sbq.push_back(mk(1'b0, 1'b0, 5'd3, 16'h3333));
    sbq.push_back(mk(1'b1, 1'b0, 5'd4, 16'h4444));
    sbq.push_back(mk(1'b0, 1'b0, 5'd3, 16'h3333));
    sbq.push_back(mk(1'b1, 1'b0, 5'd4, 16'h4444));
`else
    sbq.push_back(mk(1'b1, 1'b0, 5'd4, 16'h4444));
    sbq.push_back(mk(1'b1, 1'b0, 5'd4, 16'h4444));
    sbq.push_back(mk(1'b1, 1'b0, 5'd4, 16'h4444));
    sbq.push_back(mk(1'b0, 1'b0, 5'd3, 16'h3333));
`endif
    drive(1'b0, 1'b1, 1'b0, 5'd3, '0);
    drive(1'b1, 1'b1, 1'b0, 5'd4, '0);
    acks = 0;
    n = 0;
    while (acks < 4 && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (bus.f_ack || bus.d_ack) begin
        acks++;
`ifndef MEM_ARB_ROUND_ROBIN_EN
        if (acks == 3) bus.d_req = 1'b0;
`endif
        if (acks == 4) begin
          bus.f_req = 1'b0;
          bus.d_req = 1'b0;
        end
      end
    end
    chk("tie_acks", acks, 4);
    chk("tie_cycles", n, 11);
    repeat (4) @(posedge clk);
    #1;
    chk("sb_empty", sbq.size(), 0);
    chk("final_idle", bus.busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
